// File: rtl/timestamp_capture_pkg.sv
// Shared constants, sizing helper and types for the timestamp capture block.
package timestamp_capture_pkg;

    localparam int DefaultWidth = 8;
    localparam int DefaultDepth = 4;

    // Pointers carry one extra wrap bit, so level and pointer widths are the same.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef logic [level_width(DefaultDepth)-1:0] default_ptr_t;

    typedef struct packed {
        logic full;
        logic empty;
    } fifo_flags_t;

endpackage

// File: rtl/ts_fifo.sv
// Synchronous in-order FIFO with wrap-bit pointers. The storage array is not reset.
// The head read is forced to 0 while the FIFO is empty.
module ts_fifo
    import timestamp_capture_pkg::*;
#(
    parameter int Width = DefaultWidth,
    parameter int Depth = DefaultDepth
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          push_i,
    input  logic [Width-1:0]              push_data_i,
    input  logic                          pop_i,
    output logic [Width-1:0]              head_data_o,
    output fifo_flags_t                   flags_o,
    output logic [level_width(Depth)-1:0] level_o
);

    localparam int AddrW = $clog2(Depth);
    localparam int PtrW  = AddrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [PtrW-1:0]  rd_ptr_d;
    logic             full;
    logic             empty;
    logic             push_ok;
    logic             pop_ok;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

    // A push into a full FIFO is still accepted when the head leaves in the same cycle.
    assign pop_ok  = pop_i & ~empty;
    assign push_ok = push_i & (~full | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= push_data_i;
        end
    end

    assign head_data_o   = empty ? '0 : mem_q[rd_ptr_q[AddrW-1:0]];
    assign flags_o.full  = full;
    assign flags_o.empty = empty;
    assign level_o       = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/timestamp_capture.sv
// Captures `count` on each rising edge of `trigger` into an in-order FIFO.
// Tracks dropped captures with a sticky flag. Optional macro TIMESTAMP_CAPTURE_DROP_CNT_EN adds a saturating drop counter.
module timestamp_capture
    import timestamp_capture_pkg::*;
#(
    parameter int Width = DefaultWidth,
    parameter int Depth = DefaultDepth
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [Width-1:0]              count,
    input  logic                          trigger,
    output logic                          ts_valid,
    input  logic                          ts_ready,
    output logic [Width-1:0]              ts_data,
    output logic [level_width(Depth)-1:0] level,
    output logic                          overflow,
    input  logic                          clear_overflow
`ifdef TIMESTAMP_CAPTURE_DROP_CNT_EN
    ,
    output logic [Width-1:0]              drop_count
`endif
);

    logic        trig_q;
    logic        push_req;
    logic        pop;
    logic        drop;
    logic        overflow_q;
    logic        overflow_d;
    fifo_flags_t flags;

    // trig_q resets high so a trigger held through reset release does not capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trig_q <= 1'b1;
        end else begin
            trig_q <= trigger;
        end
    end

    assign push_req = trigger & ~trig_q;
    assign ts_valid = ~flags.empty;
    assign pop      = ts_valid & ts_ready;
    assign drop     = push_req & flags.full & ~pop;

    ts_fifo #(
        .Width (Width),
        .Depth (Depth)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (push_req),
        .push_data_i (count),
        .pop_i       (pop),
        .head_data_o (ts_data),
        .flags_o     (flags),
        .level_o     (level)
    );

    // When a drop and a clear coincide, the flag stays set.
    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;

`ifdef TIMESTAMP_CAPTURE_DROP_CNT_EN
    logic [Width-1:0] drop_cnt_q;
    logic [Width-1:0] drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clear_overflow) begin
            drop_cnt_d = drop ? Width'(1) : '0;
        end else if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_timestamp_capture.sv
// Scoreboard bench for timestamp_capture (Width=8, Depth=4). The driver queues expected timestamps.
// A negedge monitor pops the queue and compares on each accepted transfer.
module tb_timestamp_capture;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] count;
    logic       trigger;
    logic       ts_valid;
    logic       ts_ready;
    logic [7:0] ts_data;
    logic [2:0] level;
    logic       overflow;
    logic       clear_overflow;
`ifdef TIMESTAMP_CAPTURE_DROP_CNT_EN
    logic [7:0] drop_count;
`endif

    int         checks = 0;
    int         errors = 0;
    logic [7:0] expQ[$];

    timestamp_capture #(
        .Width (8),
        .Depth (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .count          (count),
        .trigger        (trigger),
        .ts_valid       (ts_valid),
        .ts_ready       (ts_ready),
        .ts_data        (ts_data),
        .level          (level),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
`ifdef TIMESTAMP_CAPTURE_DROP_CNT_EN
        ,
        .drop_count     (drop_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Inputs change 1 time unit after a rising edge and are held until the next one.
    task automatic applyStimulus(input logic trig, input logic [7:0] cnt, input logic rdy, input logic clr);
        trigger        = trig;
        count          = cnt;
        ts_ready       = rdy;
        clear_overflow = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [7:0] cnt, input bit expectStored);
        applyStimulus(1'b1, cnt, 1'b0, 1'b0);
        if (expectStored) expQ.push_back(cnt);
        applyStimulus(1'b0, cnt, 1'b0, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        ts_ready = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset_n && ts_valid && ts_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pop: got data %0h, expected no valid entry", ts_data);
            end else begin
                checkOutput("ts_data", {24'h0, ts_data}, {24'h0, expQ.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL timeout: got no end of test, expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        reset_n        = 1'b0;
        trigger        = 1'b1;
        count          = 8'h00;
        ts_ready       = 1'b0;
        clear_overflow = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ts_valid", 32'(ts_valid), 32'h0);
        checkOutput("reset_ts_data", 32'(ts_data), 32'h0);
        checkOutput("reset_level", 32'(level), 32'h0);
        checkOutput("reset_overflow", 32'(overflow), 32'h0);

        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
        checkOutput("held_trigger_level", 32'(level), 32'h0);
        checkOutput("held_trigger_valid", 32'(ts_valid), 32'h0);

        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h10, 1'b0, 1'b0);
        expQ.push_back(8'h10);
        checkOutput("single_valid", 32'(ts_valid), 32'h1);
        checkOutput("single_level", 32'(level), 32'h1);
        applyStimulus(1'b0, 8'h11, 1'b1, 1'b0);
        ts_ready = 1'b0;
        checkOutput("after_pop_valid", 32'(ts_valid), 32'h0);
        checkOutput("after_pop_data", 32'(ts_data), 32'h0);
        checkOutput("after_pop_level", 32'(level), 32'h0);

        capture(8'd1, 1'b1);
        capture(8'd3, 1'b1);
        capture(8'd5, 1'b1);
        capture(8'd7, 1'b1);
        checkOutput("full_level", 32'(level), 32'h4);
        checkOutput("full_no_overflow", 32'(overflow), 32'h0);
        capture(8'd9, 1'b0);
        checkOutput("drop_level", 32'(level), 32'h4);
        checkOutput("drop_overflow", 32'(overflow), 32'h1);
        drain(4);
        checkOutput("drained_level", 32'(level), 32'h0);
        checkOutput("overflow_sticky", 32'(overflow), 32'h1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        clear_overflow = 1'b0;
        checkOutput("overflow_cleared", 32'(overflow), 32'h0);

        capture(8'd1, 1'b1);
        capture(8'd3, 1'b1);
        capture(8'd5, 1'b1);
        capture(8'd7, 1'b1);
        applyStimulus(1'b1, 8'd9, 1'b1, 1'b0);
        expQ.push_back(8'd9);
        applyStimulus(1'b0, 8'd9, 1'b0, 1'b0);
        checkOutput("push_pop_full_level", 32'(level), 32'h4);
        checkOutput("push_pop_full_overflow", 32'(overflow), 32'h0);
        drain(4);

        capture(8'hFF, 1'b1);
        capture(8'h00, 1'b1);
        checkOutput("wrap_level", 32'(level), 32'h2);
        drain(2);

        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
        expQ.push_back(8'h20);
        checkOutput("held_high_level", 32'(level), 32'h1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        drain(1);

        capture(8'h44, 1'b0);
        capture(8'h55, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_valid", 32'(ts_valid), 32'h0);
        checkOutput("midreset_level", 32'(level), 32'h0);
        checkOutput("midreset_data", 32'(ts_data), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

`ifdef TIMESTAMP_CAPTURE_DROP_CNT_EN
        checkOutput("drop_count_reset", 32'(drop_count), 32'h0);
        capture(8'hA0, 1'b1);
        capture(8'hA1, 1'b1);
        capture(8'hA2, 1'b1);
        capture(8'hA3, 1'b1);
        for (int i = 0; i < 300; i++) capture(8'(i), 1'b0);
        checkOutput("drop_count_saturated", 32'(drop_count), 32'hFF);
        applyStimulus(1'b1, 8'hEE, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'hEE, 1'b0, 1'b0);
        checkOutput("drop_clear_same_cycle_count", 32'(drop_count), 32'h1);
        checkOutput("drop_clear_same_cycle_overflow", 32'(overflow), 32'h1);
        drain(4);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        clear_overflow = 1'b0;
        checkOutput("drop_count_cleared", 32'(drop_count), 32'h0);
`endif

        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'h0);
        checkOutput("final_level", 32'(level), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
